// File: rtl/progrom_load_arbiter.sv
// Program ROM port arbiter: fetcher pass-through in RUN, UART byte loader in LOAD.
// Loader packs big-endian bytes into words and writes them from address 0 upward.
module progrom_load_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int IDLE_TIMEOUT = 100000
) (
    input  logic              iCpuClock,
    input  logic              iCpuReset,
    input  logic              iLoadRequest,
    input  logic              iByteValid,
    input  logic [7:0]        iByte,
    input  logic [ADDR_W-1:0] iFetchAddr,
    output logic [ADDR_W-1:0] oRomAddr,
    output logic [31:0]       oRomWriteData,
    output logic              oRomWriteEnable,
    output logic              oCpuHold,
    output logic              oLoadDone,
    output logic [ADDR_W:0]   oWordCount
);

    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_FINISH} state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              last_wr;

    // Write to the top address ends the load; nothing after it is accepted.
    assign last_wr = wr_q && (ptr_q == {ADDR_W{1'b1}});

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_RUN: begin
                if (iLoadRequest) begin
                    state_d = ST_LOAD;
                    idx_d   = 2'd0;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end
            end
            ST_LOAD: begin
                if (wr_q) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
                if (last_wr) begin
                    state_d = ST_FINISH;
                end else if (iByteValid) begin
                    tmo_d = '0;
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: asm_d[23:16] = iByte;
                        2'd1: asm_d[15:8]  = iByte;
                        2'd2: asm_d[7:0]   = iByte;
                        2'd3: begin
                            wdata_d = {asm_q, iByte};
                            wr_d    = 1'b1;
                        end
                    endcase
                end else begin
                    if (tmo_q != TMO_MAX)
                        tmo_d = tmo_q + 1'b1;
                    // An empty load never times out; a partial word is simply dropped.
                    if (tmo_q == TMO_MAX && cnt_q != '0 && !wr_q)
                        state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            state_q <= ST_RUN;
            idx_q   <= 2'd0;
            asm_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign oCpuHold        = (state_q != ST_RUN);
    assign oLoadDone       = (state_q == ST_FINISH);
    assign oRomWriteEnable = wr_q;
    assign oRomWriteData   = wdata_q;
    assign oWordCount      = cnt_q;
    assign oRomAddr        = (state_q == ST_LOAD) ? ptr_q : iFetchAddr;

endmodule

// File: tb/tb_progrom_load_arbiter.sv
// Directed bench for progrom_load_arbiter: RUN vector table plus load sequences.
module tb_progrom_load_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    // instance A: 14-bit address
    logic        reqA, bvA;
    logic [7:0]  btA;
    logic [13:0] faA, addrA;
    logic [31:0] wdA;
    logic        weA, holdA, doneA;
    logic [14:0] wcA;
    // instance B: 3-bit address (full ROM case)
    logic        reqB, bvB;
    logic [7:0]  btB;
    logic [2:0]  faB, addrB;
    logic [31:0] wdB;
    logic        weB, holdB, doneB;
    logic [3:0]  wcB;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [13:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t logA[$];
    wr_t logB[$];
    int  doneCntA = 0;
    int  doneCntB = 0;

    always #5 clk = ~clk;

    progrom_load_arbiter #(.ADDR_W(14), .IDLE_TIMEOUT(TMO)) dutA (
        .iCpuClock(clk), .iCpuReset(rst), .iLoadRequest(reqA), .iByteValid(bvA),
        .iByte(btA), .iFetchAddr(faA), .oRomAddr(addrA), .oRomWriteData(wdA),
        .oRomWriteEnable(weA), .oCpuHold(holdA), .oLoadDone(doneA), .oWordCount(wcA));

    progrom_load_arbiter #(.ADDR_W(3), .IDLE_TIMEOUT(TMO)) dutB (
        .iCpuClock(clk), .iCpuReset(rst), .iLoadRequest(reqB), .iByteValid(bvB),
        .iByte(btB), .iFetchAddr(faB), .oRomAddr(addrB), .oRomWriteData(wdB),
        .oRomWriteEnable(weB), .oCpuHold(holdB), .oLoadDone(doneB), .oWordCount(wcB));

    always @(negedge clk) begin
        if (weA) logA.push_back('{addrA, wdA});
        if (weB) logB.push_back('{{11'd0, addrB}, wdB});
        if (doneA) doneCntA++;
        if (doneB) doneCntB++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendA(input logic [7:0] b, input int gap);
        bvA = 1'b1; btA = b; tick(); bvA = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic pulse_reqA();
        reqA = 1'b1; tick(); reqA = 1'b0;
    endtask

    // returns cycles until oLoadDone seen, or -1 if bound expired
    task automatic wait_doneA(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 10 * TMO; k++) begin
            tick();
            if (doneA) begin cyc = k; break; end
        end
    endtask

    typedef struct {
        logic [13:0] fa;
        logic        bv;
        logic [7:0]  b;
        logic [13:0] exp_addr;
        logic        exp_hold;
        logic        exp_we;
    } vec_t;

    initial begin
        vec_t vt[5];
        logic [7:0] bytes8[8];
        int base, cyc, d0, bad, done_idx;

        vt[0] = '{14'h0000, 1'b0, 8'h00, 14'h0000, 1'b0, 1'b0};
        vt[1] = '{14'h3FFF, 1'b1, 8'h12, 14'h3FFF, 1'b0, 1'b0};
        vt[2] = '{14'h0155, 1'b1, 8'h34, 14'h0155, 1'b0, 1'b0};
        vt[3] = '{14'h2AAA, 1'b1, 8'h56, 14'h2AAA, 1'b0, 1'b0};
        vt[4] = '{14'h1234, 1'b1, 8'h78, 14'h1234, 1'b0, 1'b0};
        bytes8 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

        reqA = 0; bvA = 0; btA = 0; faA = 14'h0155;
        reqB = 0; bvB = 0; btB = 0; faB = 3'd5;
        rst = 1'b1;
        #1;
        chk("rst_hold", holdA, 0);
        chk("rst_we", weA, 0);
        chk("rst_done", doneA, 0);
        chk("rst_wdata", wdA, 0);
        chk("rst_wcount", wcA, 0);
        chk("rst_addr_pass", addrA, 14'h0155);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // RUN mode: pass-through, bytes ignored
        for (int i = 0; i < 5; i++) begin
            faA = vt[i].fa; bvA = vt[i].bv; btA = vt[i].b;
            tick();
            chk($sformatf("run_vec%0d_addr", i), addrA, vt[i].exp_addr);
            chk($sformatf("run_vec%0d_hold", i), holdA, vt[i].exp_hold);
            chk($sformatf("run_vec%0d_we", i), weA, vt[i].exp_we);
        end
        bvA = 0;
        tick();
        chk("run_wcount_untouched", wcA, 0);

        // basic load with 3-cycle byte spacing
        base = logA.size(); d0 = doneCntA;
        pulse_reqA();
        chk("basic_hold_on_req", holdA, 1);
        chk("basic_addr_ptr0", addrA, 0);
        for (int i = 0; i < 8; i++) begin
            sendA(bytes8[i], 0);
            if (i == 3) begin
                chk("basic_w0_we", weA, 1);
                chk("basic_w0_addr", addrA, 0);
                chk("basic_w0_data", wdA, 32'h12345678);
            end
            if (i == 7) begin
                chk("basic_w1_we", weA, 1);
                chk("basic_w1_addr", addrA, 1);
                chk("basic_w1_data", wdA, 32'h9ABCDEF0);
            end else if (i != 3) begin
                chk($sformatf("basic_no_we_b%0d", i), weA, 0);
            end
            if (i != 7) repeat (2) tick();
        end
        wait_doneA(cyc);
        chk("basic_done_latency", cyc, TMO);
        chk("basic_wcount", wcA, 2);
        chk("basic_hold_in_finish", holdA, 1);
        chk("basic_we_in_finish", weA, 0);
        tick();
        chk("basic_done_one_cycle", doneA, 0);
        chk("basic_hold_released", holdA, 0);
        chk("basic_addr_pass", addrA, faA);
        chk("basic_done_count", doneCntA - d0, 1);
        chk("basic_nwrites", logA.size() - base, 2);
        if (logA.size() - base == 2) begin
            chk("basic_log0", {logA[base].a, logA[base].d}, {14'd0, 32'h12345678});
            chk("basic_log1", {logA[base+1].a, logA[base+1].d}, {14'd1, 32'h9ABCDEF0});
        end
        tick();
        chk("basic_wcount_held", wcA, 2);

        // partial word dropped
        base = logA.size();
        pulse_reqA();
        chk("partial_wcount_cleared", wcA, 0);
        for (int i = 0; i < 5; i++) sendA(8'hA1 + 8'(i), 1);
        wait_doneA(cyc);
        chk("partial_done_seen", cyc > 0, 1);
        chk("partial_wcount", wcA, 1);
        chk("partial_nwrites", logA.size() - base, 1);
        if (logA.size() - base == 1)
            chk("partial_log0", {logA[base].a, logA[base].d}, {14'd0, 32'hA1A2A3A4});
        tick();

        // back-to-back bytes
        base = logA.size();
        pulse_reqA();
        for (int i = 0; i < 12; i++) sendA(8'(i), 0);
        wait_doneA(cyc);
        chk("b2b_done_seen", cyc > 0, 1);
        chk("b2b_wcount", wcA, 3);
        chk("b2b_nwrites", logA.size() - base, 3);
        if (logA.size() - base == 3) begin
            chk("b2b_log0", {logA[base].a, logA[base].d}, {14'd0, 32'h00010203});
            chk("b2b_log1", {logA[base+1].a, logA[base+1].d}, {14'd1, 32'h04050607});
            chk("b2b_log2", {logA[base+2].a, logA[base+2].d}, {14'd2, 32'h08090A0B});
        end
        tick();

        // full ROM on the 3-bit instance
        base = logB.size(); d0 = doneCntB; done_idx = -1;
        reqB = 1'b1; tick(); reqB = 1'b0;
        chk("full_hold_on_req", holdB, 1);
        for (int i = 0; i < 40; i++) begin
            bvB = 1'b1; btB = 8'(i); tick(); bvB = 1'b0;
            if (doneB && done_idx < 0) begin
                done_idx = i;
                chk("full_wcount", wcB, 8);
            end
        end
        tick();
        chk("full_done_index", done_idx, 32);
        chk("full_done_count", doneCntB - d0, 1);
        chk("full_hold_released", holdB, 0);
        chk("full_addr_pass", addrB, 3'd5);
        chk("full_nwrites", logB.size() - base, 8);
        if (logB.size() - base == 8) begin
            for (int w = 0; w < 8; w++) begin
                logic [7:0] b0;
                b0 = 8'(4 * w);
                chk($sformatf("full_log%0d", w), {logB[base+w].a, logB[base+w].d},
                    {14'(w), b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3});
            end
        end

        // reset mid-load
        d0 = doneCntA;
        pulse_reqA();
        for (int i = 0; i < 6; i++) sendA(8'hC0 + 8'(i), 0);
        faA = 14'h0155;
        rst = 1'b1;
        #1;
        chk("midrst_hold", holdA, 0);
        chk("midrst_we", weA, 0);
        chk("midrst_done", doneA, 0);
        chk("midrst_wdata", wdA, 0);
        chk("midrst_wcount", wcA, 0);
        chk("midrst_addr_pass", addrA, 14'h0155);
        tick();
        rst = 1'b0;
        repeat (3 * TMO) tick();
        chk("midrst_no_done", doneCntA - d0, 0);
        chk("midrst_stays_run", holdA, 0);

        // no bytes: waits forever, load requests ignored
        d0 = doneCntA; bad = 0;
        pulse_reqA();
        for (int k = 0; k < 3 * TMO; k++) begin
            reqA = (k % 7 == 3);
            tick();
            if (!holdA || addrA != 14'd0) bad++;
        end
        reqA = 1'b0;
        chk("nobyte_hold_stays", bad, 0);
        chk("nobyte_no_done", doneCntA - d0, 0);
        chk("nobyte_wcount", wcA, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
